// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encoding.
package nibble_serial_adder_pkg;

  // Width of the single adder slice that every operand nibble passes through.
  localparam int NIBBLE_W = 4;

  // Controller states. The unused code 2'd3 is treated as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry slice shared by every nibble of the operation.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  // Ripple the carry bit by bit from bit 0 up to the carry out.
  always_comb begin : ripple
    logic carry;
    carry = cin;
    s     = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice processes the operands LS nibble first,
// with the inter-nibble carry held in a register and a valid/ready handshake on each side.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;
  logic                last_nibble;

  assign last_nibble = (cnt_q == LAST_CNT);

  // The one adder slice always sees the current low nibbles and the running carry.
  nibble_add4 u_slice (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // State register; reset drops any partial operation and returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs, decoded only from the registered state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nibble) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift one nibble per RUN cycle, publish on the last one.
  always_comb begin
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        a_sh_d  = a;
        b_sh_d  = b;
        carry_d = carryin;
        cnt_d   = '0;
      end
    end else if (state_q == RUN) begin
      a_sh_d   = a_sh_q >> NIBBLE_W;
      b_sh_d   = b_sh_q >> NIBBLE_W;
      sum_sh_d = (sum_sh_q >> NIBBLE_W) | {slice_s, {(WIDTH-NIBBLE_W){1'b0}}};
      carry_d  = slice_cout;
      if (last_nibble) begin
        cnt_d  = '0;
        sum_d  = sum_sh_d;
        cout_d = slice_cout;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Datapath registers; the published result persists through IDLE until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign sum      = sum_q;
  assign carryout = cout_q;

endmodule
